// File: rtl/rv_decode_stage.sv
// RV32I/RV32E instruction-decode stage: one-entry registered output between
// IFU and EXU, illegal-encoding detection and a halt FSM for EBREAK/illegal.
module rv_decode_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [31:0]       out_inst,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic [3:0]        out_optype,
    output logic [2:0]        out_funct3,
    output logic              out_funct7b5,
    output logic              out_we,
    output logic              halt,
    output logic [1:0]        halt_cause,
    output logic [XLEN-1:0]   halt_pc
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [3:0] OT_ALU_R   = 4'd0;
    localparam logic [3:0] OT_ALU_I   = 4'd1;
    localparam logic [3:0] OT_LOAD    = 4'd2;
    localparam logic [3:0] OT_STORE   = 4'd3;
    localparam logic [3:0] OT_BRANCH  = 4'd4;
    localparam logic [3:0] OT_JAL     = 4'd5;
    localparam logic [3:0] OT_JALR    = 4'd6;
    localparam logic [3:0] OT_LUI     = 4'd7;
    localparam logic [3:0] OT_AUIPC   = 4'd8;
    localparam logic [3:0] OT_SYS     = 4'd9;
    localparam logic [3:0] OT_FENCE   = 4'd10;
    localparam logic [3:0] OT_ILLEGAL = 4'd15;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    // Sign-extend a 32-bit immediate to the datapath width.
    function automatic logic signed [XLEN-1:0] sext_imm(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // A register index is out of range for this architecture (RV32E uses 16).
    function automatic logic reg_oob(input logic [4:0] r);
        return 32'(r) >= 32'(NREG);
    endfunction

    state_t              state_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     out_pc_q;
    logic [31:0]         out_inst_q;
    logic [REG_AW-1:0]   rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0]     imm_q;
    logic [3:0]          optype_q;
    logic [2:0]          funct3_q;
    logic                funct7b5_q;
    logic                we_q;
    logic [1:0]          pend_cause_q;
    logic [XLEN-1:0]     pend_pc_q;
    logic                halt_q;
    logic [1:0]          halt_cause_q;
    logic [XLEN-1:0]     halt_pc_q;

    logic [6:0]          opcode;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic [4:0]          rs1_f, rs2_f, rd_f;
    logic                use_rs1, use_rs2, use_rd;
    logic                bad;
    logic [3:0]          optype_raw;
    logic signed [31:0]  imm32;
    logic                illegal_d;
    logic                ebreak_d;
    logic [REG_AW-1:0]   rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0]     imm_d;
    logic [3:0]          optype_d;
    logic                we_d;
    logic                accept;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign rs1_f  = in_inst[19:15];
    assign rs2_f  = in_inst[24:20];
    assign rd_f   = in_inst[11:7];

    // Combinational decode of the offered instruction: format, immediate, legality.
    always_comb begin
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        bad        = 1'b0;
        optype_raw = OT_ILLEGAL;
        imm32      = '0;
        // The full 7-bit opcode match also rejects inst[1:0] != 2'b11 (compressed space).
        case (opcode)
            OPC_OP: begin
                optype_raw = OT_ALU_R;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                if (f7 == 7'h20)      bad = !(f3 == 3'b000 || f3 == 3'b101);
                else if (f7 != 7'h00) bad = 1'b1;
            end
            OPC_OPIMM: begin
                optype_raw = OT_ALU_I;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                if (f3 == 3'b001)      bad = (f7 != 7'h00);
                else if (f3 == 3'b101) bad = !(f7 == 7'h00 || f7 == 7'h20);
            end
            OPC_LOAD: begin
                optype_raw = OT_LOAD;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                optype_raw = OT_STORE;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                bad = (f3 >= 3'b011);
            end
            OPC_BRANCH: begin
                optype_raw = OT_BRANCH;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                         in_inst[11:8], 1'b0};
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                optype_raw = OT_JAL;
                use_rd = 1'b1;
                imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                         in_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                optype_raw = OT_JALR;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                bad = (f3 != 3'b000);
            end
            OPC_LUI: begin
                optype_raw = OT_LUI;
                use_rd = 1'b1;
                imm32 = {in_inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                optype_raw = OT_AUIPC;
                use_rd = 1'b1;
                imm32 = {in_inst[31:12], 12'b0};
            end
            OPC_SYSTEM: begin
                optype_raw = OT_SYS;
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                if (f3 == 3'b000) begin
                    bad = !(in_inst == INST_ECALL || in_inst == INST_EBREAK ||
                            in_inst == INST_MRET);
                end else if (f3 == 3'b100) begin
                    bad = 1'b1;
                end else begin
                    // CSR ops write rd; the immediate forms carry a zimm, not rs1.
                    use_rd  = 1'b1;
                    use_rs1 = !f3[2];
                end
            end
            OPC_FENCE: begin
                optype_raw = OT_FENCE;
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            default: bad = 1'b1;
        endcase

        illegal_d = bad || (use_rs1 && reg_oob(rs1_f)) || (use_rs2 && reg_oob(rs2_f)) ||
                    (use_rd && reg_oob(rd_f));
        ebreak_d  = (in_inst == INST_EBREAK);
        optype_d  = illegal_d ? OT_ILLEGAL : optype_raw;
        rs1_d     = REG_AW'(use_rs1 ? rs1_f : 5'd0);
        rs2_d     = REG_AW'(use_rs2 ? rs2_f : 5'd0);
        rd_d      = REG_AW'(use_rd ? rd_f : 5'd0);
        imm_d     = sext_imm(imm32);
        // use_rd is set exactly for the optypes that write back.
        we_d      = !illegal_d && use_rd && (rd_f != 5'd0);
    end

    assign in_ready = (state_q == ST_RUN) && !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Output entry register: load on accept, drop on consume or flush, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            optype_q    <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            we_q        <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= in_pc;
            out_inst_q  <= in_inst;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            optype_q    <= optype_d;
            funct3_q    <= f3;
            funct7b5_q  <= in_inst[30];
            we_q        <= we_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Halt FSM: a halting entry drains to EXU before halt is raised; flush aborts the drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pend_cause_q <= CAUSE_NONE;
            pend_pc_q    <= '0;
            halt_q       <= 1'b0;
            halt_cause_q <= CAUSE_NONE;
            halt_pc_q    <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept && (ebreak_d || illegal_d)) begin
                        state_q      <= ST_DRAIN;
                        pend_cause_q <= illegal_d ? CAUSE_ILLEGAL : CAUSE_EBREAK;
                        pend_pc_q    <= in_pc;
                    end
                end
                ST_DRAIN: begin
                    if (flush) begin
                        state_q      <= ST_RUN;
                        pend_cause_q <= CAUSE_NONE;
                        pend_pc_q    <= '0;
                    end else if (out_valid_q && out_ready) begin
                        state_q      <= ST_HALTED;
                        halt_q       <= 1'b1;
                        halt_cause_q <= pend_cause_q;
                        halt_pc_q    <= pend_pc_q;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_inst     = out_inst_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rd       = rd_q;
    assign out_imm      = imm_q;
    assign out_optype   = optype_q;
    assign out_funct3   = funct3_q;
    assign out_funct7b5 = funct7b5_q;
    assign out_we       = we_q;
    assign halt         = halt_q;
    assign halt_cause   = halt_cause_q;
    assign halt_pc      = halt_pc_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed instruction words with
// hand-decoded expectations, plus an RV32E instance for the register-range check.
module tb_rv_decode_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
        logic        we;
    } exp_t;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_pc, out_inst, out_imm, halt_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [3:0]  out_optype;
    logic [2:0]  out_funct3;
    logic        out_funct7b5, out_we, halt;
    logic [1:0]  halt_cause;

    logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_inst, c_in_pc, c_out_pc, c_out_inst, c_out_imm, c_halt_pc;
    logic [4:0]  c_out_rs1, c_out_rs2, c_out_rd;
    logic [3:0]  c_out_optype;
    logic [2:0]  c_out_funct3;
    logic        c_out_funct7b5, c_out_we, c_halt;
    logic [1:0]  c_halt_cause;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t vec[12];

    rv_decode_stage #(.XLEN(32), .NREG(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_optype(out_optype), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_we(out_we), .halt(halt), .halt_cause(halt_cause), .halt_pc(halt_pc)
    );

    rv_decode_stage #(.XLEN(32), .NREG(16), .REG_AW(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inst(c_in_inst), .in_pc(c_in_pc),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_pc(c_out_pc),
        .out_inst(c_out_inst), .out_rs1(c_out_rs1), .out_rs2(c_out_rs2), .out_rd(c_out_rd),
        .out_imm(c_out_imm), .out_optype(c_out_optype), .out_funct3(c_out_funct3),
        .out_funct7b5(c_out_funct7b5), .out_we(c_out_we), .halt(c_halt),
        .halt_cause(c_halt_cause), .halt_pc(c_halt_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic [3:0] op, input logic we);
        exp_t e;
        e.pc = pc; e.inst = inst; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.imm = imm; e.op = op; e.we = we;
        e.f3 = inst[14:12];
        e.f7b5 = inst[30];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one instruction, wait (bounded) for acceptance, push its expectation.
    task automatic issue(input exp_t e);
        in_valid = 1'b1;
        in_inst  = e.inst;
        in_pc    = e.pc;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("accept", in_ready, 1);
        if (in_ready) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        exp_q.delete();
        rst_n = 1'b1;
        idle(1);
    endtask

    // Monitor: checks every entry EXU consumes against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && flush) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_entry got pc=%h inst=%h want none", out_pc, out_inst);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_pc !== e.pc || out_inst !== e.inst || out_rs1 !== e.rs1 ||
                        out_rs2 !== e.rs2 || out_rd !== e.rd || out_imm !== e.imm ||
                        out_optype !== e.op || out_funct3 !== e.f3 ||
                        out_funct7b5 !== e.f7b5 || out_we !== e.we) begin
                        bad++;
                        $display("FAIL entry got pc=%h inst=%h rs1=%0d rs2=%0d rd=%0d imm=%h op=%0d f3=%0d f7b5=%0b we=%0b want pc=%h inst=%h rs1=%0d rs2=%0d rd=%0d imm=%h op=%0d f3=%0d f7b5=%0b we=%0b",
                                 out_pc, out_inst, out_rs1, out_rs2, out_rd, out_imm, out_optype,
                                 out_funct3, out_funct7b5, out_we, e.pc, e.inst, e.rs1, e.rs2,
                                 e.rd, e.imm, e.op, e.f3, e.f7b5, e.we);
                    end
                end
            end
        end
    end

    initial begin
        time t0;
        rst_n = 1'b0;
        in_inst = '0; in_pc = '0; c_in_inst = '0; c_in_pc = '0;

        vec[0]  = mk(32'h8000_0000, 32'hFFF0_0093, 0, 0, 1,  32'hFFFF_FFFF, 1, 1); // addi x1,x0,-1
        vec[1]  = mk(32'h8000_0004, 32'h0020_81B3, 1, 2, 3,  32'h0,         0, 1); // add x3,x1,x2
        vec[2]  = mk(32'h8000_0008, 32'h4073_02B3, 6, 7, 5,  32'h0,         0, 1); // sub x5,x6,x7
        vec[3]  = mk(32'h8000_000C, 32'hFFC1_2403, 2, 0, 8,  32'hFFFF_FFFC, 2, 1); // lw x8,-4(x2)
        vec[4]  = mk(32'h8000_0010, 32'h0091_2423, 2, 9, 0,  32'h8,         3, 0); // sw x9,8(x2)
        vec[5]  = mk(32'h8000_0014, 32'hFE20_8CE3, 1, 2, 0,  32'hFFFF_FFF8, 4, 0); // beq x1,x2,-8
        vec[6]  = mk(32'h8000_0018, 32'h0100_00EF, 0, 0, 1,  32'h10,        5, 1); // jal x1,16
        vec[7]  = mk(32'h8000_001C, 32'h1234_5537, 0, 0, 10, 32'h1234_5000, 7, 1); // lui x10
        vec[8]  = mk(32'h8000_0020, 32'h0020_8833, 1, 2, 16, 32'h0,         0, 1); // add x16,x1,x2
        vec[9]  = mk(32'h8000_0024, 32'h0000_0013, 0, 0, 0,  32'h0,         1, 0); // nop: rd=x0
        vec[10] = mk(32'h8000_0028, 32'h0000_1117, 0, 0, 2,  32'h0000_1000, 8, 1); // auipc x2,1
        vec[11] = mk(32'h8000_002C, 32'h0042_80E7, 5, 0, 1,  32'h4,         6, 1); // jalr x1,4(x5)

        do_reset();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halt", halt, 0);
        chk("rst_halt_cause", halt_cause, 0);
        chk("rst_halt_pc", halt_pc, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_in_ready", in_ready, 1);

        // RV32E instance: x16 is out of range -> illegal, halts after consume
        c_out_ready = 1'b1;
        c_in_valid = 1'b1; c_in_inst = 32'h0020_8833; c_in_pc = 32'h8000_0100;
        @(negedge clk);
        chk("e_in_ready", c_in_ready, 1);
        @(posedge clk); #1; c_in_valid = 1'b0;
        @(negedge clk);
        chk("e_out_valid", c_out_valid, 1);
        chk("e_optype", c_out_optype, 15);
        chk("e_we", c_out_we, 0);
        chk("e_halt_early", c_halt, 0);
        @(negedge clk);
        chk("e_halt", c_halt, 1);
        chk("e_halt_cause", c_halt_cause, 2);
        chk("e_halt_pc", c_halt_pc, 32'h8000_0100);
        chk("e_in_ready_halted", c_in_ready, 0);
        do_reset();

        // Back-to-back stream at one instruction per cycle
        out_ready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 12; i++) issue(vec[i]);
        chk("throughput_time", 64'($time - t0), 120);
        idle(2);

        // Backpressure: held entry stays frozen, next instruction waits
        out_ready = 1'b0;
        issue(mk(32'h8000_0030, 32'h0000_0073, 0, 0, 0, 32'h0, 9, 0));       // ecall
        in_valid = 1'b1; in_inst = 32'h3002_9273; in_pc = 32'h8000_0034;   // csrrw x4,mstatus,x5
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_inst", out_inst, 32'h0000_0073);
            chk("bp_out_pc", out_pc, 32'h8000_0030);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        if (in_ready) exp_q.push_back(mk(32'h8000_0034, 32'h3002_9273, 5, 0, 4, 32'h300, 9, 1));
        @(posedge clk); #1; in_valid = 1'b0;
        idle(2);

        // EBREAK under backpressure: halt only after the entry is consumed
        out_ready = 1'b0;
        issue(mk(32'h8000_0010, 32'h0010_0073, 0, 0, 0, 32'h1, 9, 0));
        in_valid = 1'b1; in_inst = 32'h0000_0013; in_pc = 32'h8000_0014;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_halt", halt, 0);
        end
        @(posedge clk); #1; out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ebreak_halt", halt, 1);
        chk("ebreak_cause", halt_cause, 1);
        chk("ebreak_halt_pc", halt_pc, 32'h8000_0010);
        chk("ebreak_out_valid", out_valid, 0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("sticky_halt", halt, 1);
        chk("sticky_halt_pc", halt_pc, 32'h8000_0010);
        chk("halted_in_ready", in_ready, 0);
        do_reset();

        // Flush while an EBREAK is draining
        out_ready = 1'b0;
        issue(mk(32'h8000_0020, 32'h0010_0073, 0, 0, 0, 32'h1, 9, 0));
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 32'h8000_0024;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_halt", halt, 0);
        out_ready = 1'b1;
        issue(mk(32'h8000_0024, 32'hFFF0_0093, 0, 0, 1, 32'hFFFF_FFFF, 1, 1));
        idle(3);
        chk("post_flush_halt", halt, 0);

        // Asynchronous reset in the middle of a drain
        out_ready = 1'b0;
        issue(mk(32'h8000_0030, 32'h0010_0073, 0, 0, 0, 32'h1, 9, 0));
        #3; rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_halt", halt, 0);
        exp_q.delete();
        #3; rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_halt", halt, 0);
        chk("post_rst_in_ready", in_ready, 1);
        idle(1);

        // Illegal R-type (funct7=0x20 with funct3=001) halts with cause 2
        issue(mk(32'h8000_0040, 32'h4000_1033, 0, 0, 0, 32'h0, 15, 0));
        idle(2);
        chk("illegal_halt", halt, 1);
        chk("illegal_cause", halt_cause, 2);
        chk("illegal_halt_pc", halt_pc, 32'h8000_0040);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Parametrised RV32I/RV32E instruction-decode pipeline stage for the NPC core. It sits between IFU and EXU with valid/ready handshakes on both sides and a one-entry registered output. It extracts register indices, immediate and op class, flags illegal encodings, and runs a halt state machine for EBREAK and illegal instructions. The halt outputs replace the old combinational break detection; the testbench hooks `halt` to end simulation.

Parameters:
XLEN, 32, datapath width of pc/imm (32 or 64; imm sign-extended to XLEN)
NREG, 32, architectural register count (32 = RV32I, 16 = RV32E); any used reg index >= NREG is illegal
REG_AW, 5, width of rs1/rs2/rd outputs (always 5; upper bit is 0 when legal under RV32E)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash the held entry and any in-flight halt drain
in_valid  in  1  IFU offers an instruction
in_ready  out  1  stage accepts this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded entry held
out_ready  in  1  EXU consumes the entry
out_pc  out  XLEN  registered pc
out_inst  out  32  registered raw instruction
out_rs1/out_rs2/out_rd  out  REG_AW each  register indices (0 when unused by the format)
out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J; 0 for R)
out_optype  out  4  0 ALU_R,1 ALU_I,2 LOAD,3 STORE,4 BRANCH,5 JAL,6 JALR,7 LUI,8 AUIPC,9 SYS,10 FENCE,15 ILLEGAL
out_funct3  out  3  inst[14:12]
out_funct7b5  out  1  inst[30]
out_we  out  1  entry writes rd (rd!=0 and optype in ALU_R/ALU_I/LOAD/JAL/JALR/LUI/AUIPC/CSR)
halt  out  1  sticky; stage has halted
halt_cause  out  2  0 none, 1 EBREAK, 2 illegal
halt_pc  out  XLEN  pc of the halting instruction

Behaviour:
- Reset (async, rst_n=0): state RUN, out_valid=0, all out_* data=0, halt=0, halt_cause=0, halt_pc=0.
- in_ready = (state==RUN) && !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
- On accept: decode combinationally and register all out_* fields next edge; out_valid=1 (latency 1). If out_valid && out_ready and no accept: out_valid=0. Full throughput: accept and consume in the same cycle.
- Held outputs must stay stable while out_valid && !out_ready.
- Illegal: inst[1:0]!=2'b11; unknown opcode; LOAD funct3 in {011,110,111}; STORE funct3 >= 011; BRANCH funct3 in {010,011}; JALR funct3!=0; R-type funct7 not 0x00/0x20, or 0x20 with funct3 not 000/101; SLLI funct7!=0; SRLI/SRAI funct7 not 0x00/0x20; SYSTEM funct3=000 except ECALL 0x00000073, EBREAK 0x00100073, MRET 0x30200073; SYSTEM funct3=100; any used rs1/rs2/rd >= NREG. Illegal entries: optype=15, out_we=0.
- FSM: RUN -> DRAIN on accept of EBREAK or illegal, latching cause and pc into pending regs. DRAIN -> HALTED when that entry is consumed (out_valid && out_ready); halt=1 and halt_cause/halt_pc from pending regs, set the same edge. HALTED is terminal until reset; in_ready=0.
- flush: out_valid=0 next edge; DRAIN -> RUN with pending cleared; no accept in a flush cycle; HALTED unaffected.
- Reset asserted mid-DRAIN: all state cleared, no halt.
- ECALL, MRET and CSR ops: optype SYS, no halt.

Test Plan:
- Reset then stream ADDI x1,x0,-1 (0xFFF00093) pc=0x80000000, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, optype=1, out_we=1; back-to-back stream at 1/cycle.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> next instruction accepted the same cycle.
- EBREAK 0x00100073 at pc 0x80000010, out_ready held 0 for 2 cycles -> in_ready=0, halt=0 until consumed; then halt=1, cause=1, halt_pc=0x80000010 sticky.
- NREG=16: ADD x16,x1,x2 (0x00208833) -> optype=15, halt cause=2 after consume; same word with NREG=32 -> legal ALU_R, rd=16.
- Accept EBREAK then flush before consume -> out_valid=0, state RUN, halt stays 0, next instruction accepted.
- Assert rst_n=0 asynchronously during DRAIN -> out_valid, halt drop immediately; no halt after release.
